// File: rtl/icebus_status_receiver.sv
// icebus_status_receiver: 8N1 UART receiver + 18-byte status-frame parser.
// Optional inter-byte timeout enabled by defining ICEBUS_RX_TIMEOUT_EN.
module icebus_status_receiver #(
  parameter int NUMBER_OF_MOTORS = 6,
  parameter int CLOCK_SPEED_HZ   = 50_000_000,
  parameter int BAUD_RATE        = 1_000_000,
  parameter int TIMEOUT_BITS     = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic        frame_valid,
  output logic [7:0]  frame_motor,
  output logic [31:0] frame_position,
  output logic [31:0] frame_velocity,
  output logic [15:0] frame_current,
  output logic [31:0] frame_displacement,
  output logic [15:0] framing_errors,
  output logic [15:0] frame_errors
);

  localparam int CPB  = CLOCK_SPEED_HZ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam logic [7:0] NMOT = 8'(NUMBER_OF_MOTORS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT
  } samp_e;

  typedef enum logic [2:0] {
    P_HUNT0, P_HUNT1, P_ID, P_PAYLOAD, P_CHECK
  } pars_e;

  logic rx_meta_q, rx_sync_q;

  samp_e s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shr_q, shr_d;
  logic byte_done, stop_err;

  pars_e p_q, p_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  id_q, id_d;
  logic [31:0] pos_q, pos_d, vel_q, vel_d;
  logic [15:0] cur_q, cur_d;
  logic [31:0] disp_q, disp_d;

  logic        val_q, val_d;
  logic [7:0]  mot_o_q, mot_o_d;
  logic [31:0] pos_o_q, pos_o_d, vel_o_q, vel_o_d;
  logic [15:0] cur_o_q, cur_o_d;
  logic [31:0] disp_o_q, disp_o_d;
  logic        bad_frame, to_hit;

  logic [15:0] fr_err_q, fm_err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_q   <= S_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shr_q <= '0;
    end else begin
      s_q   <= s_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shr_q <= shr_d;
    end
  end

  always_comb begin
    s_d       = s_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shr_d     = shr_q;
    byte_done = 1'b0;
    stop_err  = 1'b0;
    unique case (s_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          s_d   = S_START;
          cnt_d = '0;
        end
      end
      S_START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d = '0;
          bit_d = '0;
          s_d   = rx_sync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d = '0;
          shr_d = {rx_sync_q, shr_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) s_d = S_STOP;
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            byte_done = 1'b1;
            s_d       = S_IDLE;
          end else begin
            stop_err = 1'b1;
            s_d      = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (rx_sync_q) s_d = S_IDLE;
      end
      default: s_d = S_IDLE;
    endcase
  end

`ifdef ICEBUS_RX_TIMEOUT_EN
  localparam int TO_CLKS = TIMEOUT_BITS * CPB;
  localparam int TW      = $clog2(TO_CLKS + 1);
  logic [TW-1:0] to_q;

  assign to_hit = (p_q != P_HUNT0) && !byte_done &&
                  (to_q == TW'(TO_CLKS - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      to_q <= '0;
    else if (byte_done || to_hit || p_q == P_HUNT0)
      to_q <= '0;
    else
      to_q <= to_q + 1'b1;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_q      <= P_HUNT0;
      idx_q    <= '0;
      sum_q    <= '0;
      id_q     <= '0;
      pos_q    <= '0;
      vel_q    <= '0;
      cur_q    <= '0;
      disp_q   <= '0;
      val_q    <= 1'b0;
      mot_o_q  <= '0;
      pos_o_q  <= '0;
      vel_o_q  <= '0;
      cur_o_q  <= '0;
      disp_o_q <= '0;
    end else begin
      p_q      <= p_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      id_q     <= id_d;
      pos_q    <= pos_d;
      vel_q    <= vel_d;
      cur_q    <= cur_d;
      disp_q   <= disp_d;
      val_q    <= val_d;
      mot_o_q  <= mot_o_d;
      pos_o_q  <= pos_o_d;
      vel_o_q  <= vel_o_d;
      cur_o_q  <= cur_o_d;
      disp_o_q <= disp_o_d;
    end
  end

  always_comb begin
    p_d       = p_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    id_d      = id_q;
    pos_d     = pos_q;
    vel_d     = vel_q;
    cur_d     = cur_q;
    disp_d    = disp_q;
    val_d     = 1'b0;
    mot_o_d   = mot_o_q;
    pos_o_d   = pos_o_q;
    vel_o_d   = vel_o_q;
    cur_o_d   = cur_o_q;
    disp_o_d  = disp_o_q;
    bad_frame = 1'b0;
    if (byte_done) begin
      unique case (p_q)
        P_HUNT0: begin
          if (shr_q == 8'hA5) p_d = P_HUNT1;
        end
        P_HUNT1: begin
          if (shr_q == 8'h5A)      p_d = P_ID;
          else if (shr_q == 8'hA5) p_d = P_HUNT1;
          else                     p_d = P_HUNT0;
        end
        P_ID: begin
          if (shr_q < NMOT) begin
            id_d  = shr_q;
            idx_d = '0;
            sum_d = shr_q;
            p_d   = P_PAYLOAD;
          end else begin
            bad_frame = 1'b1;
            p_d       = P_HUNT0;
          end
        end
        P_PAYLOAD: begin
          sum_d = sum_q + shr_q;
          idx_d = idx_q + 1'b1;
          if (idx_q < 4'd4)       pos_d  = {pos_q[23:0], shr_q};
          else if (idx_q < 4'd8)  vel_d  = {vel_q[23:0], shr_q};
          else if (idx_q < 4'd10) cur_d  = {cur_q[7:0], shr_q};
          else                    disp_d = {disp_q[23:0], shr_q};
          if (idx_q == 4'd13) p_d = P_CHECK;
        end
        P_CHECK: begin
          if (shr_q == sum_q) begin
            val_d    = 1'b1;
            mot_o_d  = id_q;
            pos_o_d  = pos_q;
            vel_o_d  = vel_q;
            cur_o_d  = cur_q;
            disp_o_d = disp_q;
          end else begin
            bad_frame = 1'b1;
          end
          p_d = P_HUNT0;
        end
        default: p_d = P_HUNT0;
      endcase
    end
    if (stop_err) p_d = P_HUNT0;
    // Timeout never coincides with byte_done, so at most one drop per cycle
    if (to_hit) begin
      p_d       = P_HUNT0;
      bad_frame = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fr_err_q <= '0;
      fm_err_q <= '0;
    end else begin
      if (stop_err && fr_err_q != 16'hFFFF)
        fr_err_q <= fr_err_q + 16'd1;
      if (bad_frame && fm_err_q != 16'hFFFF)
        fm_err_q <= fm_err_q + 16'd1;
    end
  end

  assign frame_valid        = val_q;
  assign frame_motor        = mot_o_q;
  assign frame_position     = pos_o_q;
  assign frame_velocity     = vel_o_q;
  assign frame_current      = cur_o_q;
  assign frame_displacement = disp_o_q;
  assign framing_errors     = fr_err_q;
  assign frame_errors       = fm_err_q;

endmodule

// File: tb/tb_icebus_status_receiver.sv
// tb_icebus_status_receiver: directed frames through the UART line,
// checking strobes, captured fields and both error counters.
module tb_icebus_status_receiver;

  localparam int CPB = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx    = 1'b1;
  logic        frame_valid;
  logic [7:0]  frame_motor;
  logic [31:0] frame_position;
  logic [31:0] frame_velocity;
  logic [15:0] frame_current;
  logic [31:0] frame_displacement;
  logic [15:0] framing_errors;
  logic [15:0] frame_errors;

  icebus_status_receiver #(
    .NUMBER_OF_MOTORS(6),
    .CLOCK_SPEED_HZ  (50_000_000),
    .BAUD_RATE       (5_000_000),
    .TIMEOUT_BITS    (20)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .rx                (rx),
    .frame_valid       (frame_valid),
    .frame_motor       (frame_motor),
    .frame_position    (frame_position),
    .frame_velocity    (frame_velocity),
    .frame_current     (frame_current),
    .frame_displacement(frame_displacement),
    .framing_errors    (framing_errors),
    .frame_errors      (frame_errors)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_bad = 0;
  int vcount = 0;
  int vlong = 0;
  logic prev_v = 1'b0;
  logic [7:0] motors[8];
  logic [7:0] fb[18];

  always @(negedge clock) begin
    if (frame_valid && prev_v) vlong++;
    if (frame_valid) begin
      motors[vcount % 8] = frame_motor;
      vcount++;
    end
    prev_v = frame_valid;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic mk_frame(input logic [7:0] id, input logic [31:0] pos,
                          input logic [31:0] vel, input logic [15:0] cur,
                          input logic [31:0] disp, input logic [7:0] adj);
    logic [7:0] s;
    fb[0] = 8'hA5;
    fb[1] = 8'h5A;
    fb[2] = id;
    for (int i = 0; i < 4; i++) begin
      fb[3 + i]  = pos[31 - 8*i -: 8];
      fb[7 + i]  = vel[31 - 8*i -: 8];
      fb[13 + i] = disp[31 - 8*i -: 8];
    end
    fb[11] = cur[15:8];
    fb[12] = cur[7:0];
    s = 8'h00;
    for (int i = 2; i < 17; i++) s = s + fb[i];
    fb[17] = s + adj;
  endtask

  task automatic tx_byte(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clock);
    if (!stop_ok) begin
      rx = 1'b1;
      repeat (CPB) @(negedge clock);
    end
  endtask

  task automatic tx_frame(input int n, input int bad_stop);
    for (int i = 0; i < n; i++) tx_byte(fb[i], i != bad_stop);
  endtask

  task automatic settle();
    repeat (3 * CPB) @(negedge clock);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] id,
                         input logic [31:0] pos, input logic [31:0] vel,
                         input logic [15:0] cur, input logic [31:0] disp);
    check({tag, "_mot"}, 32'(frame_motor), 32'(id));
    check({tag, "_pos"}, frame_position, pos);
    check({tag, "_vel"}, frame_velocity, vel);
    check({tag, "_cur"}, 32'(frame_current), 32'(cur));
    check({tag, "_disp"}, frame_displacement, disp);
  endtask

  int v0;

  initial begin
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("rst_valid", 32'(frame_valid), 0);
    chk_out("rst", 8'h00, 0, 0, 16'h0, 0);
    check("rst_fre", 32'(framing_errors), 0);
    check("rst_fme", 32'(frame_errors), 0);

    // good frame, ID 2; checksum works out to 0xF8
    v0 = vcount;
    mk_frame(8'd2, 32'h00010203, 32'hFFFFFFF6, 16'h8001, 32'h7FFFFFFF, 0);
    check("good_chkbyte", 32'(fb[17]), 32'hF8);
    tx_frame(18, -1);
    settle();
    check("good_cnt", vcount - v0, 1);
    chk_out("good", 8'd2, 32'h00010203, 32'hFFFFFFF6, 16'h8001,
            32'h7FFFFFFF);
    check("good_fre", 32'(framing_errors), 0);
    check("good_fme", 32'(frame_errors), 0);

    // bad checksum, then an immediate good frame
    v0 = vcount;
    mk_frame(8'd2, 32'h00010203, 32'hFFFFFFF6, 16'h8001, 32'h7FFFFFFF, 1);
    tx_frame(18, -1);
    settle();
    check("badchk_cnt", vcount - v0, 0);
    check("badchk_fme", 32'(frame_errors), 1);
    chk_out("badchk", 8'd2, 32'h00010203, 32'hFFFFFFF6, 16'h8001,
            32'h7FFFFFFF);
    mk_frame(8'd3, 32'h11223344, 32'h55667788, 16'h99AA, 32'hBBCCDDEE, 0);
    tx_frame(18, -1);
    settle();
    check("after_badchk_cnt", vcount - v0, 1);
    chk_out("after_badchk", 8'd3, 32'h11223344, 32'h55667788, 16'h99AA,
            32'hBBCCDDEE);

    // out-of-range ID 6
    v0 = vcount;
    mk_frame(8'd6, 32'h00010203, 32'hFFFFFFF6, 16'h8001, 32'h7FFFFFFF, 0);
    tx_frame(18, -1);
    settle();
    check("badid_cnt", vcount - v0, 0);
    check("badid_fme", 32'(frame_errors), 2);
    mk_frame(8'd5, 32'h80000000, 32'h00000001, 16'h7FFF, 32'hFFFFFFFF, 0);
    tx_frame(18, -1);
    settle();
    check("after_badid_cnt", vcount - v0, 1);
    chk_out("after_badid", 8'd5, 32'h80000000, 32'h00000001, 16'h7FFF,
            32'hFFFFFFFF);

    // low stop bit on 5th byte
    v0 = vcount;
    mk_frame(8'd2, 32'h00010203, 32'hFFFFFFF6, 16'h8001, 32'h7FFFFFFF, 0);
    tx_frame(18, 4);
    settle();
    check("stop_cnt", vcount - v0, 0);
    check("stop_fre", 32'(framing_errors), 1);
    check("stop_fme", 32'(frame_errors), 2);
    chk_out("stop", 8'd5, 32'h80000000, 32'h00000001, 16'h7FFF,
            32'hFFFFFFFF);
    mk_frame(8'd1, 32'hCAFEF00D, 32'h0BADBEEF, 16'h1234, 32'h00000042, 0);
    tx_frame(18, -1);
    settle();
    check("after_stop_cnt", vcount - v0, 1);
    chk_out("after_stop", 8'd1, 32'hCAFEF00D, 32'h0BADBEEF, 16'h1234,
            32'h00000042);

    // stall after header + 6 payload bytes
    v0 = vcount;
    mk_frame(8'd2, 32'h00010203, 32'hFFFFFFF6, 16'h8001, 32'h7FFFFFFF, 0);
    tx_frame(9, -1);
    repeat (25 * CPB) @(negedge clock);
    check("stall_cnt", vcount - v0, 0);
`ifdef ICEBUS_RX_TIMEOUT_EN
    check("stall_fme", 32'(frame_errors), 3);
    tx_frame(18, -1);
    settle();
    check("after_stall_cnt", vcount - v0, 1);
    chk_out("after_stall", 8'd2, 32'h00010203, 32'hFFFFFFF6, 16'h8001,
            32'h7FFFFFFF);
`else
    check("stall_fme", 32'(frame_errors), 2);
`endif

    // clean restart, then back-to-back frames
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst2_fme", 32'(frame_errors), 0);
    check("rst2_fre", 32'(framing_errors), 0);
    v0 = vcount;
    mk_frame(8'd0, 32'h01020304, 32'h05060708, 16'h090A, 32'h0B0C0D0E, 0);
    tx_frame(18, -1);
    mk_frame(8'd5, 32'hFFFFFFFE, 32'h7FFFFFFF, 16'hFFFF, 32'h80000001, 0);
    tx_frame(18, -1);
    settle();
    check("b2b_cnt", vcount - v0, 2);
    check("b2b_id0", 32'(motors[v0 % 8]), 0);
    check("b2b_id1", 32'(motors[(v0 + 1) % 8]), 5);
    chk_out("b2b", 8'd5, 32'hFFFFFFFE, 32'h7FFFFFFF, 16'hFFFF,
            32'h80000001);

    // reset in the middle of a byte of the third frame
    v0 = vcount;
    mk_frame(8'd3, 32'h12345678, 32'h9ABCDEF0, 16'h4321, 32'h0000FFFF, 0);
    tx_frame(7, -1);
    rx = 1'b0;
    repeat (15) @(negedge clock);
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (4 * CPB) @(negedge clock);
    check("midrst_cnt", vcount - v0, 0);
    check("midrst_valid", 32'(frame_valid), 0);
    chk_out("midrst", 8'd0, 0, 0, 16'h0, 0);
    check("midrst_fme", 32'(frame_errors), 0);
    check("midrst_fre", 32'(framing_errors), 0);
    mk_frame(8'd4, 32'h00000064, 32'hFFFFFF9C, 16'h0100, 32'h00ABCDEF, 0);
    tx_frame(18, -1);
    settle();
    check("fresh_cnt", vcount - v0, 1);
    chk_out("fresh", 8'd4, 32'h00000064, 32'hFFFFFF9C, 16'h0100,
            32'h00ABCDEF);
    check("fresh_fme", 32'(frame_errors), 0);
    check("pulse_width", vlong, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
